// File: rtl/wb_corrector_csr_mc_pkg.sv
// Shared register map, response codes and address decode helpers for the
// white balance corrector CSR block.
package wb_corrector_csr_mc_pkg;

  localparam int unsigned OFF_MODE = 0;
  localparam int unsigned OFF_CTRL = 1;
  localparam int unsigned OFF_LOCK = 2;
  localparam int unsigned OFF_STAT = 3;
  localparam int unsigned OFF_COEF = 4;

  localparam int unsigned MODE_W          = 2;
  localparam int unsigned CTRL_CAL_BIT    = 0;
  localparam int unsigned CTRL_COMMIT_BIT = 1;
  localparam int unsigned STAT_CAL_BIT    = 0;
  localparam int unsigned STAT_PEND_BIT   = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] MODE_RST    = 2'd2;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_MODE,
    ACC_CTRL,
    ACC_LOCK,
    ACC_STAT,
    ACC_COEF,
    ACC_CUR
  } acc_e;

  function automatic logic [29:0] word_off(input logic [31:0] addr, input logic [31:0] base);
    return 30'((addr - base) >> 2);
  endfunction

  // Maps a byte address to the register class it hits; misaligned or out-of-window is ACC_NONE.
  function automatic acc_e decode_acc(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned channels);
    logic [29:0] off;
    off = word_off(addr, base);
    if (addr[1:0] != 2'b00 || addr < base) return ACC_NONE;
    if (off == 30'(OFF_MODE)) return ACC_MODE;
    if (off == 30'(OFF_CTRL)) return ACC_CTRL;
    if (off == 30'(OFF_LOCK)) return ACC_LOCK;
    if (off == 30'(OFF_STAT)) return ACC_STAT;
    if (off < 30'(OFF_COEF + channels)) return ACC_COEF;
    if (off < 30'(OFF_COEF + 2 * channels)) return ACC_CUR;
    return ACC_NONE;
  endfunction

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int unsigned b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/wb_corrector_csr_mc_if.sv
// AXI4-Lite 32-bit register bus between interconnect and the CSR block.
interface wb_corrector_csr_mc_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/wb_coef_bank.sv
// Double-buffered per-channel coefficients: byte-masked shadow writes, and a
// shadow-to-active copy on the first frame start after a commit request.
module wb_coef_bank #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned COEF_W   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CHANNELS-1:0]          wr_en_i,
  input  logic [COEF_W-1:0]            wdata_i,
  input  logic [COEF_W-1:0]            wmask_i,
  input  logic                         commit_i,
  input  logic                         sof_i,
  output logic [CHANNELS*COEF_W-1:0]   shadow_o,
  output logic [CHANNELS*COEF_W-1:0]   coef_o,
  output logic                         pending_o
);

  localparam int unsigned BANK_W = CHANNELS * COEF_W;

  logic [BANK_W-1:0] shadow_q, shadow_d;
  logic [BANK_W-1:0] active_q, active_d;
  logic              pending_q, pending_d;

  // Copy samples the registered shadow, so a same-cycle write lands only in the shadow.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (wr_en_i[i]) begin
        shadow_d[i*COEF_W +: COEF_W] = (shadow_q[i*COEF_W +: COEF_W] & ~wmask_i)
                                     | (wdata_i & wmask_i);
      end
    end
    if (pending_q && sof_i) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (commit_i) pending_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign shadow_o  = shadow_q;
  assign coef_o    = active_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/wb_corrector_csr_mc.sv
// AXI4-Lite control/status registers for the multi-channel white balance
// corrector: mode, lock, calibration strobe/status and double-buffered gains.
module wb_corrector_csr_mc
  import wb_corrector_csr_mc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned COEF_W    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  wb_corrector_csr_mc_if.slave       csr_i,
  input  logic                       sof_i,
  input  logic                       cal_done_i,
  input  logic [CHANNELS*COEF_W-1:0] cur_coef_i,
  output logic [1:0]                 mode_o,
  output logic                       cal_stb_o,
  output logic                       lock_o,
  output logic [CHANNELS*COEF_W-1:0] coef_o
);

  localparam int unsigned BANK_W = CHANNELS * COEF_W;

  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  mode_q, mode_d;
  logic        lock_q, lock_d;
  logic        cal_stb_q, cal_stb_d;
  logic        cal_done_q, cal_done_d;
  logic        cal_prev_q;

  logic              aw_hs, w_hs, ar_hs, wr_fire, wr_err, wr_ok, commit;
  logic [31:0]       wr_addr, wr_data, wr_mask, wr_bits;
  logic [3:0]        wr_strb;
  logic [29:0]       wr_off, rd_off;
  acc_e              wr_acc, rd_acc;
  logic [CHANNELS-1:0] coef_wr_en;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic [BANK_W-1:0] shadow;
  logic              pending;

  assign csr_i.awready = !aw_held_q && !bvalid_q;
  assign csr_i.wready  = !w_held_q && !bvalid_q;
  assign csr_i.bvalid  = bvalid_q;
  assign csr_i.bresp   = bresp_q;
  assign csr_i.arready = !rvalid_q;
  assign csr_i.rvalid  = rvalid_q;
  assign csr_i.rdata   = rdata_q;
  assign csr_i.rresp   = rresp_q;

  // Write decode: held beats take priority over the live bus.
  always_comb begin
    aw_hs   = csr_i.awvalid && csr_i.awready;
    w_hs    = csr_i.wvalid && csr_i.wready;
    wr_addr = aw_held_q ? awaddr_q : csr_i.awaddr;
    wr_data = w_held_q ? wdata_q : csr_i.wdata;
    wr_strb = w_held_q ? wstrb_q : csr_i.wstrb;
    wr_fire = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
    wr_acc  = decode_acc(wr_addr, BASE_ADDR, CHANNELS);
    wr_off  = word_off(wr_addr, BASE_ADDR);
    wr_mask = strb_to_mask(wr_strb);
    wr_bits = wr_data & wr_mask;
    wr_err  = (wr_acc == ACC_NONE) || (wr_acc == ACC_CUR)
           || ((wr_acc == ACC_STAT) && (wr_bits[31:1] != 31'd0));
    wr_ok   = wr_fire && !wr_err;
    commit  = wr_ok && (wr_acc == ACC_CTRL) && wr_bits[CTRL_COMMIT_BIT];
    coef_wr_en = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      coef_wr_en[i] = wr_ok && (wr_acc == ACC_COEF) && (wr_off == 30'(OFF_COEF + i));
    end
  end

  // Read mux; reads zero-extend every field to the bus width.
  always_comb begin
    ar_hs   = csr_i.arvalid && csr_i.arready;
    rd_acc  = decode_acc(csr_i.araddr, BASE_ADDR, CHANNELS);
    rd_off  = word_off(csr_i.araddr, BASE_ADDR);
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_acc)
      ACC_MODE: rd_data = 32'(mode_q);
      ACC_LOCK: rd_data = 32'(lock_q);
      ACC_STAT: begin
        rd_data[STAT_CAL_BIT]  = cal_done_q;
        rd_data[STAT_PEND_BIT] = pending;
      end
      ACC_COEF: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (rd_off == 30'(OFF_COEF + i)) rd_data = 32'(shadow[i*COEF_W +: COEF_W]);
        end
      end
      ACC_CUR: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (rd_off == 30'(OFF_COEF + CHANNELS + i)) rd_data = 32'(cur_coef_i[i*COEF_W +: COEF_W]);
        end
      end
      ACC_NONE: rd_resp = RESP_SLVERR;
      default:  rd_data = '0;
    endcase
  end

  // Next-state for channel holds, responses and control registers.
  always_comb begin
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    mode_d     = mode_q;
    lock_d     = lock_q;
    cal_stb_d  = 1'b0;
    cal_done_d = cal_done_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = csr_i.awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = csr_i.wdata;
      wstrb_d  = csr_i.wstrb;
    end
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
    end
    if (bvalid_q && csr_i.bready) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end

    if (rvalid_q && csr_i.rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = rd_resp;
    end

    if (wr_ok && (wr_acc == ACC_MODE) && wr_strb[0]) mode_d = wr_data[MODE_W-1:0];
    if (wr_ok && (wr_acc == ACC_LOCK) && wr_strb[0]) lock_d = wr_data[0];
    cal_stb_d = wr_ok && (wr_acc == ACC_CTRL) && wr_bits[CTRL_CAL_BIT];

    // A new calibration edge beats a simultaneous write-1-to-clear.
    if (wr_ok && (wr_acc == ACC_STAT) && wr_bits[STAT_CAL_BIT]) cal_done_d = 1'b0;
    if (cal_done_i && !cal_prev_q) cal_done_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      mode_q     <= MODE_RST;
      lock_q     <= 1'b0;
      cal_stb_q  <= 1'b0;
      cal_done_q <= 1'b0;
      cal_prev_q <= 1'b0;
    end else begin
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      mode_q     <= mode_d;
      lock_q     <= lock_d;
      cal_stb_q  <= cal_stb_d;
      cal_done_q <= cal_done_d;
      cal_prev_q <= cal_done_i;
    end
  end

  wb_coef_bank #(
    .CHANNELS (CHANNELS),
    .COEF_W   (COEF_W)
  ) u_coef_bank (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (coef_wr_en),
    .wdata_i   (wr_data[COEF_W-1:0]),
    .wmask_i   (wr_mask[COEF_W-1:0]),
    .commit_i  (commit),
    .sof_i     (sof_i),
    .shadow_o  (shadow),
    .coef_o    (coef_o),
    .pending_o (pending)
  );

  assign mode_o    = mode_q;
  assign lock_o    = lock_q;
  assign cal_stb_o = cal_stb_q;

endmodule

// File: tb/tb_wb_corrector_csr_mc.sv
// Self-checking bench for wb_corrector_csr_mc: vector table plus hand-written
// commit, strobe, sticky-status and reset sequences, scoreboarded responses.
module tb_wb_corrector_csr_mc;
  localparam int unsigned CH = 3;
  localparam int unsigned CW = 16;
  localparam int NV = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sof = 1'b0;
  logic cal_done = 1'b0;
  logic [CH*CW-1:0] cur_coef = 48'h3333_2222_1111;
  logic [1:0] mode;
  logic cal_stb, lock;
  logic [CH*CW-1:0] coef;

  int total = 0;
  int bad = 0;
  int stb_cnt = 0;
  int stb_double = 0;
  logic stb_prev = 1'b0;

  typedef struct {logic [1:0] resp; string name;} wr_exp_t;
  typedef struct {logic [33:0] exp; string name;} rd_exp_t;
  typedef struct {
    bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; int lead;
    logic [31:0] exp_data; logic [1:0] exp_resp; string name;
  } vec_t;

  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  vec_t vecs[NV];

  wb_corrector_csr_mc_if bif();

  wb_corrector_csr_mc #(.BASE_ADDR(32'h0), .CHANNELS(CH), .COEF_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .csr_i(bif), .sof_i(sof), .cal_done_i(cal_done),
    .cur_coef_i(cur_coef), .mode_o(mode), .cal_stb_o(cal_stb), .lock_o(lock), .coef_o(coef)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cal_stb && stb_prev) stb_double++;
    if (cal_stb) stb_cnt++;
    stb_prev = cal_stb;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  // side: 0 none, 1 sof pulse in the first bus cycle, 2 raise cal_done_i in that cycle
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int side, input logic [1:0] exp_resp, input string name);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    wr_exp_t e;
    wr_q.push_back('{exp_resp, name});
    @(negedge clk);
    bif.awaddr = addr;
    bif.wdata  = data;
    bif.wstrb  = strb;
    if (lead >= 0) bif.wvalid = 1'b1;
    if (lead <= 0) bif.awvalid = 1'b1;
    if (side == 1) sof = 1'b1;
    if (side == 2) cal_done = 1'b1;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_hs = bif.awvalid && bif.awready;
      w_hs  = bif.wvalid && bif.wready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      sof = 1'b0;
      if (aw_hs) begin bif.awvalid = 1'b0; aw_done = 1; end
      if (w_hs) begin bif.wvalid = 1'b0; w_done = 1; end
      if (lead > 0 && cyc == lead && !aw_done) bif.awvalid = 1'b1;
      if (lead < 0 && cyc == -lead && !w_done) bif.wvalid = 1'b1;
    end
    cyc = 0;
    while (!bif.bvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    e = wr_q.pop_front();
    if (!bif.bvalid) begin
      bif.awvalid = 1'b0;
      bif.wvalid  = 1'b0;
      timeout({e.name, "_bresp"});
    end else begin
      check(e.name, 64'(bif.bresp), 64'(e.resp));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string name);
    int cyc;
    bit hs;
    rd_exp_t e;
    rd_q.push_back('{{exp_resp, exp_data}, name});
    @(negedge clk);
    bif.araddr  = addr;
    bif.arvalid = 1'b1;
    hs = 0; cyc = 0;
    while (!hs && cyc < 50) begin
      hs = bif.arready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bif.arvalid = 1'b0;
    cyc = 0;
    while (!bif.rvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    e = rd_q.pop_front();
    if (!bif.rvalid) timeout({e.name, "_rdata"});
    else begin
      check(e.name, 64'({bif.rresp, bif.rdata}), 64'(e.exp));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_sof(input logic [47:0] exp_after, input string name);
    @(negedge clk);
    sof = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sof = 1'b0;
    check(name, 64'(coef), 64'(exp_after));
  endtask

  initial begin
    int c0;
    bif.awaddr = '0; bif.awvalid = 1'b0; bif.wdata = '0; bif.wstrb = '0; bif.wvalid = 1'b0;
    bif.bready = 1'b1; bif.araddr = '0; bif.arvalid = 1'b0; bif.rready = 1'b1;

    vecs[0]  = '{1'b0, 32'h00,  32'h0,         4'h0, 0,  32'h2,    2'b00, "rst_mode"};
    vecs[1]  = '{1'b0, 32'h04,  32'h0,         4'h0, 0,  32'h0,    2'b00, "rst_ctrl"};
    vecs[2]  = '{1'b0, 32'h08,  32'h0,         4'h0, 0,  32'h0,    2'b00, "rst_lock"};
    vecs[3]  = '{1'b0, 32'h0C,  32'h0,         4'h0, 0,  32'h0,    2'b00, "rst_stat"};
    vecs[4]  = '{1'b0, 32'h10,  32'h0,         4'h0, 0,  32'h0,    2'b00, "rst_coef0"};
    vecs[5]  = '{1'b1, 32'h00,  32'h1,         4'hF, 0,  32'h0,    2'b00, "wr_mode"};
    vecs[6]  = '{1'b0, 32'h00,  32'h0,         4'h0, 0,  32'h1,    2'b00, "rd_mode"};
    vecs[7]  = '{1'b1, 32'h08,  32'hFFFF_FFFF, 4'hF, 1,  32'h0,    2'b00, "wr_lock"};
    vecs[8]  = '{1'b0, 32'h08,  32'h0,         4'h0, 0,  32'h1,    2'b00, "rd_lock_trunc"};
    vecs[9]  = '{1'b1, 32'h10,  32'hABCD_5678, 4'h1, -2, 32'h0,    2'b00, "wr_coef0_b0"};
    vecs[10] = '{1'b1, 32'h10,  32'h0000_9900, 4'h2, 2,  32'h0,    2'b00, "wr_coef0_b1"};
    vecs[11] = '{1'b1, 32'h10,  32'hFFFF_0000, 4'hC, 0,  32'h0,    2'b00, "wr_coef0_hi"};
    vecs[12] = '{1'b0, 32'h10,  32'h0,         4'h0, 0,  32'h9978, 2'b00, "rd_coef0"};
    vecs[13] = '{1'b0, 32'h1C,  32'h0,         4'h0, 0,  32'h1111, 2'b00, "rd_cur0"};
    vecs[14] = '{1'b0, 32'h24,  32'h0,         4'h0, 0,  32'h3333, 2'b00, "rd_cur2"};
    vecs[15] = '{1'b1, 32'h1C,  32'hDEAD,      4'hF, 0,  32'h0,    2'b10, "wr_cur0"};
    vecs[16] = '{1'b0, 32'h1C,  32'h0,         4'h0, 0,  32'h1111, 2'b00, "rd_cur0_after"};
    vecs[17] = '{1'b1, 32'h0C,  32'h2,         4'hF, 0,  32'h0,    2'b10, "wr_stat_bit1"};
    vecs[18] = '{1'b0, 32'h0C,  32'h0,         4'h0, 0,  32'h0,    2'b00, "rd_stat_after"};
    vecs[19] = '{1'b1, 32'h100, 32'h3,         4'hF, 0,  32'h0,    2'b10, "wr_unmapped"};
    vecs[20] = '{1'b0, 32'h00,  32'h0,         4'h0, 0,  32'h1,    2'b00, "rd_mode_after"};
    vecs[21] = '{1'b0, 32'h100, 32'h0,         4'h0, 0,  32'h0,    2'b10, "rd_unmapped"};
    vecs[22] = '{1'b0, 32'h02,  32'h0,         4'h0, 0,  32'h0,    2'b10, "rd_misaligned"};
    vecs[23] = '{1'b0, 32'h28,  32'h0,         4'h0, 0,  32'h0,    2'b10, "rd_past_end"};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mode_o", 64'(mode), 64'd2);
    check("rst_lock_o", 64'(lock), 64'd0);
    check("rst_coef_o", 64'(coef), 64'd0);
    check("rst_cal_stb", 64'(cal_stb), 64'd0);
    check("rst_readies", 64'({bif.awready, bif.wready, bif.arready}), 64'd7);
    check("rst_valids", 64'({bif.bvalid, bif.rvalid}), 64'd0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, 0,
                               vecs[i].exp_resp, vecs[i].name);
      else do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, vecs[i].name);
    end
    check("mode_o_after_table", 64'(mode), 64'd1);
    check("lock_o_after_table", 64'(lock), 64'd1);

    // Shadow write with W leading AW, then commit and frame start.
    do_write(32'h14, 32'h1234, 4'hF, 3, 0, 2'b00, "wr_coef1_wfirst");
    check("coef_o_before_commit", 64'(coef), 64'd0);
    do_write(32'h04, 32'h2, 4'hF, 0, 0, 2'b00, "wr_commit");
    check("coef_o_pending", 64'(coef), 64'd0);
    do_read(32'h0C, 32'h2, 2'b00, "stat_pending");
    @(negedge clk);
    sof = 1'b1;
    check("coef_o_at_sof", 64'(coef), 64'd0);
    @(posedge clk);
    @(negedge clk);
    sof = 1'b0;
    check("coef_o_after_sof", 64'(coef), 64'h0000_1234_9978);
    do_read(32'h0C, 32'h0, 2'b00, "stat_cleared");

    // Commit coincident with frame start is not consumed by that frame start.
    do_write(32'h18, 32'h00AB, 4'hF, 0, 0, 2'b00, "wr_coef2");
    do_write(32'h04, 32'h2, 4'hF, 0, 1, 2'b00, "wr_commit_sof");
    check("coef_o_no_copy", 64'(coef), 64'h0000_1234_9978);
    do_read(32'h0C, 32'h2, 2'b00, "stat_pending2");
    pulse_sof(48'h00AB_1234_9978, "coef_o_second_sof");
    do_read(32'h0C, 32'h0, 2'b00, "stat_cleared2");

    // Calibration strobes: two real pulses, none when byte 0 is not strobed.
    c0 = stb_cnt;
    do_write(32'h04, 32'h1, 4'hF, 0, 0, 2'b00, "wr_cal1");
    do_write(32'h04, 32'h1, 4'hF, 0, 0, 2'b00, "wr_cal2");
    do_write(32'h04, 32'h1, 4'h0, 0, 0, 2'b00, "wr_cal_nostrb");
    repeat (3) @(negedge clk);
    check("cal_stb_count", 64'(stb_cnt - c0), 64'd2);
    check("cal_stb_single", 64'(stb_double), 64'd0);

    // Sticky status: a rising edge beats a simultaneous clear.
    do_write(32'h0C, 32'h1, 4'hF, 0, 2, 2'b00, "w1c_with_rise");
    do_read(32'h0C, 32'h1, 2'b00, "stat_set_wins");
    do_write(32'h0C, 32'h1, 4'hF, 0, 0, 2'b00, "w1c_alone");
    do_read(32'h0C, 32'h0, 2'b00, "stat_cleared3");
    cal_done = 1'b0;

    // Reset with an address beat held abandons the write.
    @(negedge clk);
    bif.awaddr  = 32'h08;
    bif.awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.awvalid = 1'b0;
    check("aw_held", 64'(bif.awready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_readies", 64'({bif.awready, bif.wready, bif.arready}), 64'd7);
    check("mid_rst_valids", 64'({bif.bvalid, bif.rvalid}), 64'd0);
    check("mid_rst_outputs", 64'({mode, lock, coef}), {13'd0, 2'd2, 1'b0, 48'd0});
    do_write(32'h08, 32'h1, 4'hF, 0, 0, 2'b00, "wr_lock_post_rst");
    do_read(32'h08, 32'h1, 2'b00, "rd_lock_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_corrector_csr_mc.md
Name: wb_corrector_csr_mc

Overview:
Parametrised AXI4-Lite control/status block for the multi-channel white balance corrector.
- Per-channel manual gain coefficients are double-buffered: software writes shadow copies, and shadows are copied to the active outputs only on a frame-start pulse after a commit request. This prevents mid-frame tearing.
- Adds a sticky calibration-done status (write-1-to-clear), SLVERR on unmapped or illegal accesses, and AW/W accepted in any order.
- Sits between the AXI4-Lite interconnect and the corrector datapath.

Parameters:
BASE_ADDR  32'h0000_0000  byte base address of the register window
CHANNELS   3              number of colour channels (1..8)
COEF_W     16             coefficient width in bits (1..32)

Ports:
clk_i        input   1                  clock
rst_i        input   1                  reset
csr_i        slave   axi4_lite_if       AXI4-Lite slave, 32-bit data
sof_i        input   1                  frame-start pulse from video timing, one cycle
cal_done_i   input   1                  calibration-finished level from datapath
cur_coef_i   input   CHANNELS*COEF_W    coefficients currently applied by datapath
mode_o       output  2                  operating mode
cal_stb_o    output  1                  one-cycle calibration start pulse
lock_o       output  1                  manual coefficient lock
coef_o       output  CHANNELS*COEF_W    active manual coefficients, channel i at [i*COEF_W +: COEF_W]

Behaviour:
- Interface: reset rst_i, asynchronous, active-high; clock clk_i.
- Register map (word offset, byte = BASE_ADDR + 4*offset):
  - 0 MODE_CR, RW, [1:0], reset 2.
  - 1 CTRL_CR, WO. Bit0 = cal_stb; bit1 = commit. Reads return 0.
  - 2 LOCK_CR, RW, [0], reset 0.
  - 3 STAT_SR. Bit0 = cal_done, sticky, write 1 to clear. Bit1 = commit_pending, RO.
  - 4..4+CHANNELS-1 COEF_CR[i], RW shadow, [COEF_W-1:0], reset 0. Bytewise wstrb applies.
  - 4+CHANNELS..4+2*CHANNELS-1 CUR_COEF_SR[i], RO, zero-extended cur_coef_i slice.
- Decode is unmapped if outside the window or if addr[1:0] != 0.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W are latched independently in either order or the same cycle.
  - The register update happens in the cycle both are held. bvalid asserts the next cycle. Holds clear on b handshake.
  - One write outstanding at a time.
  - bresp = 2'b10 for unmapped, CUR_COEF_SR, or any STAT_SR bit other than bit0. Such writes have no side effects. Otherwise bresp = 0.
- Read channel:
  - arready = !rvalid. rdata/rvalid are registered one cycle after the ar handshake and held until rready.
  - Unmapped reads return rresp 2'b10, rdata 0.
- cal_stb_o: writing CTRL_CR bit0 = 1 with wstrb[0] produces exactly one high cycle, the cycle after the write takes effect.
- commit:
  - Writing CTRL_CR bit1 = 1 sets commit_pending.
  - On the first sof_i with commit_pending = 1, all active coefficients take the shadow values and commit_pending clears; coef_o updates the cycle after that sof_i.
  - A sof_i in the same cycle as the commit write is not consumed; the copy waits for the next sof_i.
  - A COEF_CR write in the same cycle as the copy: the active copy gets the pre-write shadow; the shadow keeps the new value.
- cal_done sticky bit: set on the rising edge of cal_done_i. If a set and a W1C clear happen in the same cycle, the set wins.
- Reset values: mode_o = 2, cal_stb_o = 0, lock_o = 0, coef_o = 0, commit_pending = 0, all valids 0, rdata 0, resp 0, ready signals 1.
- Reset mid-transaction abandons any held AW/W and any pending response.
- Register width rules: writes truncate to the field width; reads zero-extend to 32 bits.

Decomposition:
- Package wb_corrector_csr_mc_pkg: register offset constants, field bit positions, RESP_OKAY/RESP_SLVERR, and an offset-to-access-type function.
- One sub-module, wb_coef_bank: shadow/active registers per channel with wstrb merge and commit-on-sof logic.

Test Plan:
- After reset, read offsets 0–3 -> 2, 0, 0, 0 with rresp 0. coef_o = 0, mode_o = 2.
- W before AW by 3 cycles, write COEF_CR[1] = 0x1234 -> bresp 0, coef_o unchanged. Then commit, then sof_i -> coef_o[31:16] = 0x1234 one cycle after sof_i; STAT_SR bit1 reads 0.
- Commit write coincident with sof_i -> no copy. The next sof_i performs the copy. STAT_SR bit1 reads 1 in between.
- CTRL_CR = 0x1 written twice -> exactly two single-cycle cal_stb_o pulses.
- cal_done_i rising edge in the same cycle as W1C of STAT_SR bit0 -> bit0 reads 1. A later W1C alone -> reads 0.
- Write to CUR_COEF_SR[0] and read of BASE_ADDR + 0x100 -> bresp/rresp = 2'b10 with no state change; rdata 0.
